// File: rtl/uart_cmd_engine.sv
// Byte-stream command engine: parses A5-framed commands from rx, answers with
// ACK/NAK on tx and drives injection, filter and mode registers.
module uart_cmd_engine #(
  parameter int NUM_CH         = 2,
  parameter int REPORT_BYTES   = 8,
  parameter int MAX_PAYLOAD    = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic                             rx_ready,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic [NUM_CH*REPORT_BYTES*8-1:0] inj_report,
  output logic [NUM_CH-1:0]                inj_valid,
  input  logic [NUM_CH-1:0]                inj_ack,
  output logic [31:0]                      filter_mask,
  output logic [7:0]                       mode,
  output logic [15:0]                      err_count
);

  localparam int PW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD);
  localparam logic [7:0]    INJ_LEN = 8'(1 + REPORT_BYTES);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, LEN, PAYLOAD, CKSUM, EXEC, RESP0, RESP1
  } state_t;

  state_t          state;
  logic [7:0]      cmd_q, len_q, sum_q, idx_q, resp_code;
  logic            cksum_ok;
  logic [TW-1:0]   timer;
  logic [7:0]      payload [MAX_PAYLOAD];
  logic [31:0]     filter_bytes;
  logic [NUM_CH-1:0] chan_hit;
  logic [7:0]      req_len, nak_code;
  logic            known_cmd, rx_fire;
  logic [15:0]     err_inc;

  assign rx_ready = !rst && (state inside {IDLE, CMD, LEN, PAYLOAD, CKSUM});
  assign rx_fire  = rx_valid && rx_ready;
  assign err_inc  = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

  // Small payload buffers may be shorter than a filter word; missing bytes read as zero.
  for (genvar i = 0; i < 4; i++) begin : g_fb
    if (i < MAX_PAYLOAD) begin : g_in
      assign filter_bytes[i*8 +: 8] = payload[i];
    end else begin : g_out
      assign filter_bytes[i*8 +: 8] = 8'h00;
    end
  end

  always_comb begin
    chan_hit = '0;
    for (int c = 0; c < NUM_CH; c++) chan_hit[c] = (payload[0] == 8'(c));
    req_len   = 8'd0;
    known_cmd = 1'b1;
    case (cmd_q)
      8'h10:   req_len = INJ_LEN;
      8'h20:   req_len = 8'd4;
      8'h21:   req_len = 8'd1;
      8'h30:   req_len = 8'd0;
      default: known_cmd = 1'b0;
    endcase
    nak_code = 8'h00;
    if (!cksum_ok)                                          nak_code = 8'h01;
    else if (len_q > MAX_LEN)                               nak_code = 8'h03;
    else if (!known_cmd)                                    nak_code = 8'h02;
    else if (len_q != req_len)                              nak_code = 8'h03;
    else if (cmd_q == 8'h10 && chan_hit == '0)              nak_code = 8'h04;
    else if (cmd_q == 8'h10 && |(chan_hit & inj_valid))     nak_code = 8'h05;
  end

  always_ff @(posedge clk) begin
    if (rx_fire && state == PAYLOAD && idx_q < MAX_LEN) payload[idx_q[PW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      inj_report  <= '0;
      inj_valid   <= '0;
      filter_mask <= 32'hFFFF_FFFF;
      mode        <= 8'h01;
      err_count   <= 16'd0;
      timer       <= '0;
      cmd_q       <= 8'h00;
      len_q       <= 8'h00;
      sum_q       <= 8'h00;
      idx_q       <= 8'h00;
      resp_code   <= 8'h00;
      cksum_ok    <= 1'b0;
    end else begin
      inj_valid <= inj_valid & ~inj_ack;
      case (state)
        IDLE: begin
          timer <= '0;
          if (rx_fire && rx_data == 8'hA5) state <= CMD;
        end
        CMD, LEN, PAYLOAD, CKSUM: begin
          if (rx_fire) begin
            timer <= '0;
            if (state == CMD) begin
              cmd_q <= rx_data;
              sum_q <= rx_data;
              state <= LEN;
            end else if (state == LEN) begin
              len_q <= rx_data;
              sum_q <= sum_q + rx_data;
              idx_q <= 8'h00;
              state <= (rx_data == 8'h00) ? CKSUM : PAYLOAD;
            end else if (state == PAYLOAD) begin
              sum_q <= sum_q + rx_data;
              idx_q <= idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) state <= CKSUM;
            end else begin
              cksum_ok <= (rx_data == sum_q);
              state    <= EXEC;
            end
          end else if (timer == T_LAST) begin
            // Stalled frame: drop it and report a timeout NAK.
            state     <= RESP0;
            tx_valid  <= 1'b1;
            tx_data   <= 8'h15;
            resp_code <= 8'h06;
            err_count <= err_inc;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EXEC: begin
          state    <= RESP0;
          tx_valid <= 1'b1;
          if (nak_code != 8'h00) begin
            tx_data   <= 8'h15;
            resp_code <= nak_code;
            err_count <= err_inc;
          end else begin
            tx_data   <= 8'h06;
            resp_code <= cmd_q;
            case (cmd_q)
              8'h10: begin
                for (int c = 0; c < NUM_CH; c++) begin
                  if (chan_hit[c]) begin
                    inj_valid[c] <= 1'b1;
                    for (int k = 0; k < REPORT_BYTES; k++)
                      inj_report[(c*REPORT_BYTES+k)*8 +: 8] <= payload[1+k];
                  end
                end
              end
              8'h20:   filter_mask <= filter_bytes;
              8'h21:   mode        <= payload[0];
              default: ;
            endcase
          end
        end
        RESP0: begin
          if (tx_ready) begin
            tx_data <= resp_code;
            state   <= RESP1;
          end
        end
        RESP1: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Randomised bench for uart_cmd_engine: frames are built and scored against a
// frame-level model of the command rules.
module tb_uart_cmd_engine;

  localparam int NUM_CH = 2;
  localparam int RB     = 8;
  localparam int MAXP   = 12;
  localparam int TO     = 200;
  localparam int W      = NUM_CH*RB*8;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     rx_data, tx_data, mode;
  logic           rx_valid, rx_ready, tx_valid, tx_ready;
  logic [W-1:0]   inj_report;
  logic [NUM_CH-1:0] inj_valid, inj_ack;
  logic [31:0]    filter_mask;
  logic [15:0]    err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]        m_mode;
  logic [31:0]       m_filter;
  logic [7:0]        m_report [NUM_CH][RB];
  logic [NUM_CH-1:0] m_valid;
  int                m_err;
  logic [7:0]        frame [$];

  uart_cmd_engine #(.NUM_CH(NUM_CH), .REPORT_BYTES(RB), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .inj_report(inj_report), .inj_valid(inj_valid), .inj_ack(inj_ack),
    .filter_mask(filter_mask), .mode(mode), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] expReport();
    logic [W-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < RB; k++) v[(c*RB+k)*8 +: 8] = m_report[c][k];
    return v;
  endfunction

  function automatic void modelReset();
    m_mode   = 8'h01;
    m_filter = 32'hFFFF_FFFF;
    m_valid  = '0;
    m_err    = 0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < RB; k++) m_report[c][k] = 8'h00;
  endfunction

  // Appends the checksum over everything already in the frame, optionally corrupted.
  function automatic void closeFrame(input logic [7:0] corrupt);
    logic [7:0] s = 8'h00;
    foreach (frame[i]) s = s + frame[i];
    frame.push_back(s ^ corrupt);
  endfunction

  function automatic void modelExpect(output logic [7:0] r0, output logic [7:0] r1);
    logic [7:0] cmd, len, ck, s, code, need;
    logic       known;
    int         p0;
    cmd = frame[0];
    len = frame[1];
    ck  = frame[frame.size()-1];
    s   = 8'h00;
    for (int i = 0; i < frame.size()-1; i++) s = s + frame[i];
    p0    = (len > 0) ? int'(frame[2]) : 0;
    known = 1'b1;
    need  = 8'h00;
    case (cmd)
      8'h10:   need = 8'(RB + 1);
      8'h20:   need = 8'd4;
      8'h21:   need = 8'd1;
      8'h30:   need = 8'd0;
      default: known = 1'b0;
    endcase
    code = 8'h00;
    if (ck != s)                                 code = 8'h01;
    else if (int'(len) > MAXP)                   code = 8'h03;
    else if (!known)                             code = 8'h02;
    else if (len != need)                        code = 8'h03;
    else if (cmd == 8'h10 && p0 >= NUM_CH)       code = 8'h04;
    else if (cmd == 8'h10 && m_valid[p0])        code = 8'h05;
    if (code != 8'h00) begin
      r0 = 8'h15;
      r1 = code;
      m_err++;
    end else begin
      r0 = 8'h06;
      r1 = cmd;
      if (cmd == 8'h10) begin
        m_valid[p0] = 1'b1;
        for (int k = 0; k < RB; k++) m_report[p0][k] = frame[3+k];
      end else if (cmd == 8'h20) begin
        m_filter = {frame[5], frame[4], frame[3], frame[2]};
      end else if (cmd == 8'h21) begin
        m_mode = frame[2];
      end
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) checkOutput("rx_ready_wait", 0, 1);
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic sendFrame();
    applyStimulus(8'hA5);
    foreach (frame[i]) applyStimulus(frame[i]);
  endtask

  task automatic recvResponse(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input int lo, input int hi);
    int w = 0;
    int n;
    bit took;
    while (!tx_valid && w <= hi) begin
      tick();
      w++;
    end
    checkOutput({tag, "_latency"}, (w >= lo && w <= hi), 1);
    if (!tx_valid) return;
    checkOutput({tag, "_mode"}, mode, m_mode);
    checkOutput({tag, "_filter"}, filter_mask, m_filter);
    checkOutput({tag, "_inj_valid"}, inj_valid, m_valid);
    checkOutput({tag, "_inj_report"}, inj_report, expReport());
    checkOutput({tag, "_err_count"}, err_count, 16'(m_err));
    for (int j = 0; j < 2; j++) begin
      checkOutput({tag, (j == 0) ? "_tx0" : "_tx1"}, {tx_valid, tx_data}, {1'b1, (j == 0) ? e0 : e1});
      n = 0;
      do begin
        tx_ready = ($urandom_range(0, 3) != 0);
        took     = tx_ready;
        tick();
        n++;
        if (!took) checkOutput({tag, "_hold"}, {tx_valid, tx_data}, {1'b1, (j == 0) ? e0 : e1});
      end while (!took && n < 20);
      tx_ready = 1'b0;
    end
    checkOutput({tag, "_done_tx_valid"}, tx_valid, 0);
    checkOutput({tag, "_done_rx_ready"}, rx_ready, 1);
  endtask

  task automatic resetDut(input string tag);
    rst = 1'b1;
    rx_valid = 1'b0;
    inj_ack = '0;
    tick();
    checkOutput({tag, "_rx_ready"}, rx_ready, 0);
    checkOutput({tag, "_tx_valid"}, tx_valid, 0);
    checkOutput({tag, "_tx_data"}, tx_data, 8'h00);
    checkOutput({tag, "_inj"}, {inj_valid, inj_report}, '0);
    checkOutput({tag, "_filter"}, filter_mask, 32'hFFFF_FFFF);
    checkOutput({tag, "_mode"}, mode, 8'h01);
    checkOutput({tag, "_err"}, err_count, 16'd0);
    rst = 1'b0;
    #1;
    checkOutput({tag, "_rx_ready_after"}, rx_ready, 1);
    modelReset();
  endtask

  task automatic ackChannel(input int c);
    inj_ack = NUM_CH'(1) << c;
    tick();
    inj_ack = '0;
    m_valid[c] = 1'b0;
    checkOutput("ack_clear", inj_valid, m_valid);
  endtask

  task automatic runFrame(input string tag);
    logic [7:0] r0, r1;
    sendFrame();
    checkOutput({tag, "_exec_rx_ready"}, rx_ready, 0);
    modelExpect(r0, r1);
    recvResponse(tag, r0, r1, 1, 1);
  endtask

  function automatic logic [7:0] payByte();
    return ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] cmd, len;
    int kind;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; inj_ack = '0;
    modelReset();
    tick(); tick();
    resetDut("reset");

    // Directed frames with literal responses.
    frame = '{8'h30, 8'h00, 8'h30};
    sendFrame(); void'(modelExpect(cmd, len));
    recvResponse("ping", 8'h06, 8'h30, 1, 1);

    frame = '{8'h21, 8'h01, 8'h03, 8'h25};
    sendFrame(); modelExpect(cmd, len);
    recvResponse("set_mode", 8'h06, 8'h21, 1, 1);
    checkOutput("mode_is_03", mode, 8'h03);

    frame = '{8'h10, 8'h09, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1E};
    sendFrame(); modelExpect(cmd, len);
    recvResponse("inject", 8'h06, 8'h10, 1, 1);
    checkOutput("inject_valid", inj_valid, 2'b10);
    checkOutput("inject_ch1_b2", inj_report[(1*RB+2)*8 +: 8], 8'h04);
    sendFrame(); modelExpect(cmd, len);
    recvResponse("inject_busy", 8'h15, 8'h05, 1, 1);
    ackChannel(1);
    checkOutput("inject_acked", inj_valid[1], 0);

    resetDut("reset2");
    frame = '{8'h30, 8'h00, 8'h31};
    sendFrame(); modelExpect(cmd, len);
    recvResponse("bad_cksum", 8'h15, 8'h01, 1, 1);
    checkOutput("bad_cksum_err", err_count, 16'd1);
    frame = '{8'h30, 8'h00, 8'h30};
    sendFrame(); modelExpect(cmd, len);
    recvResponse("ping_after", 8'h06, 8'h30, 1, 1);

    applyStimulus(8'hA5);
    applyStimulus(8'h20);
    m_err++;
    recvResponse("timeout", 8'h15, 8'h06, TO - 2, TO + 2);
    checkOutput("timeout_filter", filter_mask, 32'hFFFF_FFFF);

    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 2) == 0) ackChannel($urandom_range(0, NUM_CH-1));
      frame.delete();
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin frame.push_back(8'h30); frame.push_back(8'h00); end
        1, 6: begin frame.push_back(8'h21); frame.push_back(8'h01); frame.push_back(payByte()); end
        2: begin
          frame.push_back(8'h20); frame.push_back(8'h04);
          repeat (4) frame.push_back(payByte());
        end
        3, 4, 5: begin
          frame.push_back(8'h10); frame.push_back(8'(RB + 1));
          frame.push_back((kind == 5) ? 8'($urandom_range(NUM_CH, 255)) : 8'($urandom_range(0, NUM_CH-1)));
          repeat (RB) frame.push_back(payByte());
        end
        7: begin
          do cmd = 8'($urandom); while (cmd inside {8'h10, 8'h20, 8'h21, 8'h30});
          len = 8'($urandom_range(0, 3));
          frame.push_back(cmd); frame.push_back(len);
          repeat (int'(len)) frame.push_back(payByte());
        end
        8: begin
          case ($urandom_range(0, 3))
            0: begin cmd = 8'h30; len = 8'd1; end
            1: begin cmd = 8'h21; len = 8'd2; end
            2: begin cmd = 8'h20; len = 8'd5; end
            default: begin cmd = 8'h10; len = 8'(RB + 2); end
          endcase
          frame.push_back(cmd); frame.push_back(len);
          repeat (int'(len)) frame.push_back(payByte());
        end
        default: begin
          len = 8'($urandom_range(MAXP + 1, MAXP + 8));
          frame.push_back(8'h10); frame.push_back(len);
          repeat (int'(len)) frame.push_back(payByte());
        end
      endcase
      closeFrame((kind == 6) ? 8'($urandom_range(1, 255)) : 8'h00);
      runFrame("random");
    end

    // Reset while the first response byte is stalled.
    tx_ready = 1'b0;
    frame = '{8'h30, 8'h00, 8'h30};
    sendFrame();
    kind = 0;
    while (!tx_valid && kind < 10) begin tick(); kind++; end
    checkOutput("stall_tx_valid", tx_valid, 1);
    resetDut("resp_reset");

    // Reset mid-frame must leave no side effect.
    applyStimulus(8'hA5);
    applyStimulus(8'h21);
    applyStimulus(8'h01);
    resetDut("frame_reset");
    frame = '{8'h30, 8'h00, 8'h30};
    sendFrame(); modelExpect(cmd, len);
    recvResponse("ping_final", 8'h06, 8'h30, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
